// File: rtl/digit_update_scheduler.sv
// Three-requester, three-slot digit value scheduler: writes land in shadow registers and are committed to the overlays at frame start.
// Optional highlight sequencing is compiled in with `define DIGIT_HIGHLIGHT_EN.
module digit_update_scheduler #(
  parameter int VAL_W     = 8,
  parameter int MAX_VAL   = 99,
  parameter int HL_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         req_valid,
  input  logic [5:0]         req_slot,
  input  logic [3*VAL_W-1:0] req_value,
  output logic [2:0]         req_ready,
  input  logic               frame_start,
  output logic [VAL_W-1:0]   disp_val0,
  output logic [VAL_W-1:0]   disp_val1,
  output logic [VAL_W-1:0]   disp_val2,
  output logic [2:0]         use_red,
  output logic [2:0]         pend,
  output logic               err
);

  // state  | meaning
  // ARB    | round-robin grant of writes into the shadow registers
  // COMMIT | one cycle: pending shadows copied to the display, grants blocked
  typedef enum logic {ARB = 1'b0, COMMIT = 1'b1} state_t;

  localparam logic [VAL_W-1:0] MAX_V = VAL_W'(MAX_VAL);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_ptr;
  logic [VAL_W-1:0] r_shadow [3];
  logic [VAL_W-1:0] r_disp   [3];
  logic [2:0]       r_pend;
  logic             r_err;

  logic [2:0]       w_gnt;
  logic             w_gnt_vld;
  logic [1:0]       w_gnt_idx;
  logic [1:0]       w_wr_slot;
  logic [VAL_W-1:0] w_wr_raw;
  logic [VAL_W-1:0] w_wr_val;
  logic [1:0]       w_ptr_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ARB;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB:     if (frame_start) w_state_nxt = COMMIT;
      COMMIT:  w_state_nxt = ARB;
      default: w_state_nxt = ARB;
    endcase
  end

  // Priority order rotates with the pointer: ptr, ptr+1, ptr+2 (mod 3).
  always_comb begin
    w_gnt_idx = 2'd0;
    w_gnt_vld = 1'b0;
    if (r_state == ARB && !frame_start) begin
      case (r_ptr)
        2'd1: begin
          if      (req_valid[1]) begin w_gnt_idx = 2'd1; w_gnt_vld = 1'b1; end
          else if (req_valid[2]) begin w_gnt_idx = 2'd2; w_gnt_vld = 1'b1; end
          else if (req_valid[0]) begin w_gnt_idx = 2'd0; w_gnt_vld = 1'b1; end
        end
        2'd2: begin
          if      (req_valid[2]) begin w_gnt_idx = 2'd2; w_gnt_vld = 1'b1; end
          else if (req_valid[0]) begin w_gnt_idx = 2'd0; w_gnt_vld = 1'b1; end
          else if (req_valid[1]) begin w_gnt_idx = 2'd1; w_gnt_vld = 1'b1; end
        end
        default: begin
          if      (req_valid[0]) begin w_gnt_idx = 2'd0; w_gnt_vld = 1'b1; end
          else if (req_valid[1]) begin w_gnt_idx = 2'd1; w_gnt_vld = 1'b1; end
          else if (req_valid[2]) begin w_gnt_idx = 2'd2; w_gnt_vld = 1'b1; end
        end
      endcase
    end
  end

  always_comb begin
    w_gnt     = 3'b000;
    w_wr_slot = req_slot[1:0];
    w_wr_raw  = req_value[VAL_W-1:0];
    w_ptr_nxt = 2'd1;
    case (w_gnt_idx)
      2'd1: begin
        w_wr_slot = req_slot[3:2];
        w_wr_raw  = req_value[2*VAL_W-1:VAL_W];
        w_ptr_nxt = 2'd2;
      end
      2'd2: begin
        w_wr_slot = req_slot[5:4];
        w_wr_raw  = req_value[3*VAL_W-1:2*VAL_W];
        w_ptr_nxt = 2'd0;
      end
      default: ;
    endcase
    if (w_gnt_vld) w_gnt[w_gnt_idx] = 1'b1;
  end

  assign w_wr_val = (w_wr_raw > MAX_V) ? MAX_V : w_wr_raw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr  <= 2'd0;
      r_pend <= 3'b000;
      r_err  <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        r_shadow[k] <= '0;
        r_disp[k]   <= '0;
      end
    end else if (r_state == COMMIT) begin
      for (int k = 0; k < 3; k++) begin
        if (r_pend[k]) r_disp[k] <= r_shadow[k];
      end
      r_pend <= 3'b000;
    end else if (w_gnt_vld) begin
      r_ptr <= w_ptr_nxt;
      // Slot code 3 has no target: the write is consumed but only flagged.
      if (w_wr_slot == 2'd3) begin
        r_err <= 1'b1;
      end else begin
        r_shadow[w_wr_slot] <= w_wr_val;
        r_pend[w_wr_slot]   <= 1'b1;
      end
    end
  end

`ifdef DIGIT_HIGHLIGHT_EN
  localparam logic [7:0] HL_LAST = 8'(HL_FRAMES - 1);

  logic [7:0] r_hl_cnt;
  logic [2:0] r_use_red;

  // Counter reloads on every real update, so the newest slots own the colour.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hl_cnt  <= 8'd0;
      r_use_red <= 3'b000;
    end else if (r_state == COMMIT) begin
      if (r_pend != 3'b000) begin
        r_use_red <= r_pend;
        r_hl_cnt  <= HL_LAST;
      end else if (r_hl_cnt == 8'd0) begin
        r_use_red <= 3'b000;
      end else begin
        r_hl_cnt <= r_hl_cnt - 8'd1;
      end
    end
  end

  assign use_red = r_use_red;
`else
  assign use_red = 3'b000;
`endif

  assign req_ready = w_gnt;
  assign disp_val0 = r_disp[0];
  assign disp_val1 = r_disp[1];
  assign disp_val2 = r_disp[2];
  assign pend      = r_pend;
  assign err       = r_err;

endmodule
